line_raster: RTL and testbench
==============================

LINE_RASTER -- requirements
Module: line_raster

Interface
REQ-001 Parameter X_MAX, 639, largest legal x coordinate.
REQ-002 Parameter Y_MAX, 479, largest legal y coordinate.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cmd_valid  in  1  decoded command present on shape/color/opdata.
REQ-006 cmd_ready  out  1  block can accept a command this cycle.
REQ-007 shape  in  4  decoded shape code; 4'b0000 = line.
REQ-008 color  in  16  decoded pixel color.
REQ-009 opdata  in  76  decoded operands: [75:57] point A, [56:38] point B, [37:0] unused for lines.
REQ-010 pix_valid  out  1  pixel present on pix_x/pix_y/pix_color.
REQ-011 pix_ready  in  1  downstream frame-buffer writer accepts the pixel.
REQ-012 pix_x  out  10  pixel x.
REQ-013 pix_y  out  9  pixel y.
REQ-014 pix_color  out  16  latched command color.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 done  out  1  one-cycle pulse after the last pixel of a line is accepted.
REQ-017 err  out  1  one-cycle pulse when a command is dropped.

Function
REQ-018 Point encoding SHALL be x = point[18:9], y = point[8:0]; A = (x0,y0) start, B = (x1,y1) end.
REQ-019 States SHALL be IDLE, SETUP, DRAW, DONE; cmd_ready = 1 only in IDLE.
REQ-020 Handshake: a command is accepted in the cycle where cmd_valid && cmd_ready; all fields are latched then.
REQ-021 On acceptance with shape != 4'b0000, or with any of x0, x1 > X_MAX or y0, y1 > Y_MAX, the block SHALL drop the command, pulse err in the next cycle, and stay in IDLE.
REQ-022 On acceptance of a legal line, the next state SHALL be SETUP.
REQ-023 SETUP (one cycle) SHALL compute the following, then go to DRAW:
  - dx = |x1-x0|;
  - dy = -|y1-y0|;
  - sx = +1 if x0 < x1, else -1;
  - sy = +1 if y0 < y1, else -1;
  - e = dx + dy, held in a 12-bit signed register;
  - cur = (x0, y0).
REQ-024 Latency: accept in cycle N, SETUP in N+1, first pix_valid in N+2.
REQ-025 DRAW SHALL drive pix_valid = 1 with pix_x/pix_y = cur and pix_color = the latched color.
REQ-026 While pix_valid && !pix_ready, pix_x, pix_y, pix_color and all internal state SHALL hold.
REQ-027 On pix_valid && pix_ready with cur == (x1,y1), the block SHALL go to DONE.
REQ-028 On pix_valid && pix_ready with cur != (x1,y1), the block SHALL step, with e2 = 2*e taken from the pre-update e:
  - if e2 >= dy: x += sx and e += dy;
  - if e2 <= dx: y += sy and e += dx;
  - both steps apply in the same cycle when both conditions hold.
REQ-029 Pixel count SHALL be max(dx, -dy) + 1, one pixel per accepted handshake.
REQ-030 A degenerate line (A == B) SHALL emit exactly one pixel.
REQ-031 DONE SHALL assert done for one cycle, then return to IDLE; pix_valid = 0 in DONE.
REQ-032 cmd_valid asserted outside IDLE SHALL be ignored; the command is not lost, because cmd_ready = 0 holds it upstream.
REQ-033 pix_valid SHALL be 0 in IDLE, SETUP and DONE.

Reset
REQ-034 When rst = 1 at a clock edge, the block SHALL enter IDLE regardless of state, aborting any line in progress with no done pulse.
REQ-035 Output values while in reset / immediately after:
  - cmd_ready = 1;
  - pix_valid = 0, busy = 0, done = 0, err = 0;
  - pix_x = 0, pix_y = 0, pix_color = 0.
REQ-036 The first command SHALL be acceptable in the first cycle with rst = 0.

Verification
REQ-037 Horizontal line, shape 0, A = (0,0), B = (3,0), pix_ready = 1 -> pixels (0,0), (1,0), (2,0), (3,0) on 4 consecutive cycles starting at N+2; done pulse at N+6; cmd_ready = 1 at N+7.
REQ-038 Reverse diagonal, A = (5,5), B = (2,2) -> pixels (5,5), (4,4), (3,3), (2,2).
REQ-039 Steep line, A = (0,0), B = (1,3) -> pixels (0,0), (0,1), (1,2), (1,3); single point A = B = (639,479) -> one pixel (639,479), then done.
REQ-040 Backpressure on A = (0,0), B = (3,0), with pix_ready toggling 1,0,0,1,... -> outputs stable during stall cycles; same 4 pixels, in order, without duplicates.
REQ-041 Drop cases: shape = 4'b0001 -> err pulse at N+1, no pix_valid, busy = 0; x0 = 640 on a line -> err pulse, no pixels.
REQ-042 Reset mid-line: assert rst after the 2nd pixel of a (0,0)->(9,0) line -> next cycle pix_valid = 0, busy = 0, no done pulse; a following command draws from its own start point.

Source files
------------

// File: rtl/line_raster.sv
// line_raster: Bresenham line rasteriser for a frame-buffer pixel stream.
//
// Accepts one decoded draw command at a time and emits one pixel per
// accepted downstream handshake. Only shape 4'b0000 (line) is drawn.
// Unsupported shapes and out-of-range endpoints are dropped with an err pulse.
//
// Ports
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_cmd_valid / o_cmd_ready command handshake (ready only while idle)
//   i_shape, i_color          decoded shape code and pixel colour
//   i_opdata                  [75:57] point A, [56:38] point B, {x[18:9], y[8:0]}
//   o_pix_valid / i_pix_ready pixel handshake toward the frame-buffer writer
//   o_pix_x, o_pix_y          current pixel coordinate
//   o_pix_color               colour latched with the command
//   o_busy                    high whenever a command is in progress
//   o_done                    one-cycle pulse after the last pixel is taken
//   o_err                     one-cycle pulse when a command is dropped
module line_raster #(
    parameter int X_MAX = 639,
    parameter int Y_MAX = 479
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [3:0]  i_shape,
    input  logic [15:0] i_color,
    input  logic [75:0] i_opdata,
    output logic        o_pix_valid,
    input  logic        i_pix_ready,
    output logic [9:0]  o_pix_x,
    output logic [8:0]  o_pix_y,
    output logic [15:0] o_pix_color,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    localparam logic [9:0] LP_X_MAX = 10'(X_MAX);
    localparam logic [8:0] LP_Y_MAX = 9'(Y_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [9:0]         r_x0, r_x1, r_cur_x;
    logic [8:0]         r_y0, r_y1, r_cur_y;
    logic [15:0]        r_color;
    logic signed [11:0] r_dx, r_dy, r_e;
    logic               r_sx_neg, r_sy_neg;
    logic               r_err;

    logic [9:0]         w_cmd_x0, w_cmd_x1;
    logic [8:0]         w_cmd_y0, w_cmd_y1;
    logic               w_accept, w_legal, w_at_end, w_step;
    logic               w_step_x, w_step_y;
    logic [9:0]         w_dx_abs;
    logic [8:0]         w_dy_abs;
    logic signed [12:0] w_e2, w_dx13, w_dy13;
    logic signed [11:0] w_e_nxt;
    logic [9:0]         w_cur_x_nxt;
    logic [8:0]         w_cur_y_nxt;
    logic               w_unused_opdata;

    assign w_cmd_x0 = i_opdata[75:66];
    assign w_cmd_y0 = i_opdata[65:57];
    assign w_cmd_x1 = i_opdata[56:47];
    assign w_cmd_y1 = i_opdata[46:38];
    assign w_unused_opdata = ^i_opdata[37:0];

    assign w_accept = i_cmd_valid && (r_state == ST_IDLE);
    assign w_legal  = (i_shape == 4'b0000) &&
                      (w_cmd_x0 <= LP_X_MAX) && (w_cmd_x1 <= LP_X_MAX) &&
                      (w_cmd_y0 <= LP_Y_MAX) && (w_cmd_y1 <= LP_Y_MAX);

    // Endpoint distances from the latched command, consumed in SETUP.
    assign w_dx_abs = (r_x1 > r_x0) ? (r_x1 - r_x0) : (r_x0 - r_x1);
    assign w_dy_abs = (r_y1 > r_y0) ? (r_y1 - r_y0) : (r_y0 - r_y1);

    // Error term doubled in 13 bits so 2*e cannot wrap; dx/dy sign-extended to match.
    assign w_e2   = signed'({r_e, 1'b0});
    assign w_dx13 = signed'({r_dx[11], r_dx});
    assign w_dy13 = signed'({r_dy[11], r_dy});

    assign w_at_end = (r_cur_x == r_x1) && (r_cur_y == r_y1);
    assign w_step   = (r_state == ST_DRAW) && i_pix_ready && !w_at_end;
    assign w_step_x = (w_e2 >= w_dy13);
    assign w_step_y = (w_e2 <= w_dx13);

    // Both axis corrections use the pre-update error term.
    assign w_e_nxt = r_e + (w_step_x ? r_dy : 12'sd0) + (w_step_y ? r_dx : 12'sd0);
    assign w_cur_x_nxt = !w_step_x ? r_cur_x :
                         (r_sx_neg ? (r_cur_x - 10'd1) : (r_cur_x + 10'd1));
    assign w_cur_y_nxt = !w_step_y ? r_cur_y :
                         (r_sy_neg ? (r_cur_y - 9'd1) : (r_cur_y + 9'd1));

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_cmd_valid && w_legal) begin
                    w_state_nxt = ST_SETUP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: w_state_nxt = ST_DRAW;
            ST_DRAW: begin
                if (i_pix_ready && w_at_end) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_DRAW;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Command latch, line setup and per-pixel Bresenham stepping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_x0     <= 10'd0;
            r_x1     <= 10'd0;
            r_y0     <= 9'd0;
            r_y1     <= 9'd0;
            r_cur_x  <= 10'd0;
            r_cur_y  <= 9'd0;
            r_color  <= 16'd0;
            r_dx     <= 12'sd0;
            r_dy     <= 12'sd0;
            r_e      <= 12'sd0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_accept && !w_legal;
            if (w_accept) begin
                r_x0    <= w_cmd_x0;
                r_y0    <= w_cmd_y0;
                r_x1    <= w_cmd_x1;
                r_y1    <= w_cmd_y1;
                r_color <= i_color;
            end
            if (r_state == ST_SETUP) begin
                r_dx     <= signed'({2'b00, w_dx_abs});
                r_dy     <= 12'sd0 - signed'({3'b000, w_dy_abs});
                r_e      <= signed'({2'b00, w_dx_abs}) - signed'({3'b000, w_dy_abs});
                r_sx_neg <= !(r_x0 < r_x1);
                r_sy_neg <= !(r_y0 < r_y1);
                r_cur_x  <= r_x0;
                r_cur_y  <= r_y0;
            end else if (w_step) begin
                r_cur_x <= w_cur_x_nxt;
                r_cur_y <= w_cur_y_nxt;
                r_e     <= w_e_nxt;
            end
        end
    end

    assign o_cmd_ready = (r_state == ST_IDLE);
    assign o_pix_valid = (r_state == ST_DRAW);
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = (r_state == ST_DONE);
    assign o_err       = r_err;
    assign o_pix_x     = r_cur_x;
    assign o_pix_y     = r_cur_y;
    assign o_pix_color = r_color;

endmodule

// File: tb/tb_line_raster.sv
// tb_line_raster: directed bench for line_raster with a pixel-list model.
module tb_line_raster;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  shape;
    logic [15:0] color;
    logic [75:0] opdata;
    logic        pix_valid;
    logic        pix_ready;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [15:0] pix_color;
    logic        busy;
    logic        done;
    logic        err;

    line_raster #(.X_MAX(639), .Y_MAX(479)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_shape(shape), .i_color(color), .i_opdata(opdata),
        .o_pix_valid(pix_valid), .i_pix_ready(pix_ready),
        .o_pix_x(pix_x), .o_pix_y(pix_y), .o_pix_color(pix_color),
        .o_busy(busy), .o_done(done), .o_err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    // Counters and model state: written only by the compare process.
    int   n_vec = 0;
    int   n_bad = 0;
    int   d_rd  = 0;
    bit   armed = 1'b0;
    bit   exp_err = 1'b0;
    bit   stall_prev = 1'b0;
    int   prev_x, prev_y, prev_c;
    pix_t exp_q[$];

    // Directed checks posted by the stimulus process, evaluated by the compare process.
    string d_name [0:511];
    int    d_act  [0:511];
    int    d_exp  [0:511];
    int    d_wr = 0;

    // Line pixel list straight from the error-term rules, in plain integers.
    function automatic int model_line(input int x0, input int y0, input int x1, input int y1,
                                      output int px [0:1023], output int py [0:1023]);
        int dx, dy, sx, sy, e, e2, x, y, n;
        dx = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy = -((y1 > y0) ? y1 - y0 : y0 - y1);
        sx = (x0 < x1) ? 1 : -1;
        sy = (y0 < y1) ? 1 : -1;
        e  = dx + dy;
        x  = x0;
        y  = y0;
        n  = 0;
        for (int guard = 0; guard < 1024; guard++) begin
            px[n] = x;
            py[n] = y;
            n++;
            if (x == x1 && y == y1) break;
            e2 = 2 * e;
            if (e2 >= dy) begin x += sx; e += dy; end
            if (e2 <= dx) begin y += sy; e += dx; end
        end
        return n;
    endfunction

    task automatic post(input string nm, input int act, input int req);
        if (d_wr < 512) begin
            d_name[d_wr] = nm;
            d_act[d_wr]  = act;
            d_exp[d_wr]  = req;
            d_wr++;
        end
    endtask

    // Compare process: DUT outputs against the model on every cycle.
    always @(negedge clk) begin : cmp
        int   mx [0:1023];
        int   my [0:1023];
        int   mn, cx0, cy0, cx1, cy1;
        pix_t p;
        while (d_rd < d_wr) begin
            n_vec++;
            if (d_act[d_rd] != d_exp[d_rd]) begin
                n_bad++;
                $display("FAIL %s: actual %0d, required %0d", d_name[d_rd], d_act[d_rd], d_exp[d_rd]);
            end
            d_rd++;
        end
        if (armed) begin
            n_vec++;
            if (busy !== !cmd_ready) begin
                n_bad++;
                $display("FAIL busy_vs_ready: busy %0b cmd_ready %0b at %0t", busy, cmd_ready, $time);
            end
            n_vec++;
            if (err !== exp_err) begin
                n_bad++;
                $display("FAIL err_pulse: actual %0b, required %0b at %0t", err, exp_err, $time);
            end
            if (pix_valid === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL pix_extra: actual (%0d,%0d), required no pixel at %0t", pix_x, pix_y, $time);
                end else if (int'(pix_x) != exp_q[0].x || int'(pix_y) != exp_q[0].y ||
                             int'(pix_color) != exp_q[0].c) begin
                    n_bad++;
                    $display("FAIL pix_value: actual (%0d,%0d,%h), required (%0d,%0d,%h) at %0t",
                             pix_x, pix_y, pix_color, exp_q[0].x, exp_q[0].y, exp_q[0].c, $time);
                end
                if (stall_prev) begin
                    n_vec++;
                    if (int'(pix_x) != prev_x || int'(pix_y) != prev_y || int'(pix_color) != prev_c) begin
                        n_bad++;
                        $display("FAIL stall_hold: actual (%0d,%0d,%h), required (%0d,%0d,%h)",
                                 pix_x, pix_y, pix_color, prev_x, prev_y, prev_c);
                    end
                end
            end
            if (done === 1'b1) begin
                n_vec++;
                if (exp_q.size() != 0) begin
                    n_bad++;
                    $display("FAIL done_early: actual %0d pixels left, required 0", exp_q.size());
                end
            end
        end
        stall_prev = armed && (pix_valid === 1'b1) && !pix_ready && !rst;
        prev_x = int'(pix_x);
        prev_y = int'(pix_y);
        prev_c = int'(pix_color);
        exp_err = 1'b0;
        if (rst) begin
            exp_q.delete();
            armed = 1'b1;
        end else if (armed) begin
            if (pix_valid && pix_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (cmd_valid && cmd_ready) begin
                cx0 = int'(opdata[75:66]);
                cy0 = int'(opdata[65:57]);
                cx1 = int'(opdata[56:47]);
                cy1 = int'(opdata[46:38]);
                if (shape != 4'd0 || cx0 > 639 || cx1 > 639 || cy0 > 479 || cy1 > 479) begin
                    exp_err = 1'b1;
                end else begin
                    mn = model_line(cx0, cy0, cx1, cy1, mx, my);
                    for (int i = 0; i < mn; i++) begin
                        p.x = mx[i];
                        p.y = my[i];
                        p.c = int'(color);
                        exp_q.push_back(p);
                    end
                end
            end
        end
    end

    // Pin the model against hand-computed pixel lists.
    task automatic pin4(input string nm, input int x0, input int y0, input int x1, input int y1,
                        input int ex [0:3], input int ey [0:3]);
        int mx [0:1023];
        int my [0:1023];
        int n;
        n = model_line(x0, y0, x1, y1, mx, my);
        post({nm, "_n"}, n, 4);
        for (int i = 0; i < 4; i++) begin
            post({nm, "_x"}, mx[i], ex[i]);
            post({nm, "_y"}, my[i], ey[i]);
        end
    endtask

    // Caller is at posedge+1; returns at posedge+1 of the cycle after the post-done check.
    task automatic run_line(input string nm, input int x0, input int y0, input int x1, input int y1,
                            input logic [15:0] col, input logic [3:0] rpat);
        int mx [0:1023];
        int my [0:1023];
        int nexp, first, hs, last, dcyc, adx, ady;
        nexp = model_line(x0, y0, x1, y1, mx, my);
        adx = (x1 > x0) ? x1 - x0 : x0 - x1;
        ady = (y1 > y0) ? y1 - y0 : y0 - y1;
        post({nm, "_model_len"}, nexp, ((adx > ady) ? adx : ady) + 1);
        cmd_valid = 1'b1;
        shape     = 4'd0;
        color     = col;
        opdata    = {10'(x0), 9'(y0), 10'(x1), 9'(y1), 38'd0};
        pix_ready = 1'b1;
        @(negedge clk);
        post({nm, "_ready_N"}, int'(cmd_ready), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        post({nm, "_setup_valid"}, int'(pix_valid), 0);
        post({nm, "_setup_busy"}, int'(busy), 1);
        first = -1; hs = 0; last = -1; dcyc = -1;
        for (int k = 2; k < 300 && dcyc < 0; k++) begin
            @(posedge clk); #1;
            pix_ready = rpat[(k - 2) % 4];
            @(negedge clk);
            if (pix_valid && first < 0) first = k;
            if (pix_valid && pix_ready) begin
                hs++;
                if (hs == nexp) last = k;
            end
            if (done) dcyc = k;
        end
        post({nm, "_first_valid_cyc"}, first, 2);
        post({nm, "_pixel_count"}, hs, nexp);
        post({nm, "_done_cyc"}, dcyc, last + 1);
        @(posedge clk); #1;
        pix_ready = 1'b1;
        @(negedge clk);
        post({nm, "_ready_after"}, int'(cmd_ready), 1);
        post({nm, "_done_once"}, int'(done), 0);
        @(posedge clk); #1;
    endtask

    task automatic drop_cmd(input string nm, input logic [3:0] shp,
                            input int x0, input int y0, input int x1, input int y1);
        int nv;
        cmd_valid = 1'b1;
        shape     = shp;
        color     = 16'h0F0F;
        opdata    = {10'(x0), 9'(y0), 10'(x1), 9'(y1), 38'd0};
        @(negedge clk);
        post({nm, "_ready_N"}, int'(cmd_ready), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        shape     = 4'd0;
        @(negedge clk);
        post({nm, "_err_N1"}, int'(err), 1);
        post({nm, "_busy_N1"}, int'(busy), 0);
        post({nm, "_ready_N1"}, int'(cmd_ready), 1);
        nv = int'(pix_valid);
        @(posedge clk); #1;
        @(negedge clk);
        post({nm, "_err_N2"}, int'(err), 0);
        for (int k = 0; k < 3; k++) begin
            nv += int'(pix_valid);
            @(posedge clk); #1;
            @(negedge clk);
        end
        post({nm, "_no_pixels"}, nv, 0);
        @(posedge clk); #1;
    endtask

    // Stimulus.
    initial begin : stim
        int nbad;
        rst = 1'b1; cmd_valid = 1'b0; shape = 4'd0; color = 16'd0; opdata = 76'd0; pix_ready = 1'b0;

        pin4("pin_horiz", 0, 0, 3, 0, '{0, 1, 2, 3}, '{0, 0, 0, 0});
        pin4("pin_rdiag", 5, 5, 2, 2, '{5, 4, 3, 2}, '{5, 4, 3, 2});
        pin4("pin_steep", 0, 0, 1, 3, '{0, 0, 1, 1}, '{0, 1, 2, 3});

        repeat (3) @(posedge clk);
        @(negedge clk);
        post("rst_cmd_ready", int'(cmd_ready), 1);
        post("rst_pix_valid", int'(pix_valid), 0);
        post("rst_busy", int'(busy), 0);
        post("rst_done", int'(done), 0);
        post("rst_err", int'(err), 0);
        post("rst_pix_x", int'(pix_x), 0);
        post("rst_pix_y", int'(pix_y), 0);
        post("rst_pix_color", int'(pix_color), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_line("horiz", 0, 0, 3, 0, 16'hABCD, 4'b1111);
        run_line("rdiag", 5, 5, 2, 2, 16'h1234, 4'b1111);
        run_line("steep", 0, 0, 1, 3, 16'h00FF, 4'b1111);
        run_line("point", 639, 479, 639, 479, 16'hFFFF, 4'b1111);
        run_line("bp_horiz", 0, 0, 3, 0, 16'h5A5A, 4'b1001);
        run_line("bp_long", 10, 20, 2, 5, 16'hC3C3, 4'b1011);
        drop_cmd("drop_shape", 4'b0001, 1, 1, 2, 2);
        drop_cmd("drop_x0", 4'b0000, 640, 0, 3, 0);
        drop_cmd("drop_y1", 4'b0000, 0, 0, 3, 480);

        // Reset after the second pixel of a long line.
        cmd_valid = 1'b1; shape = 4'd0; color = 16'h7777;
        opdata = {10'd0, 9'd0, 10'd9, 9'd0, 38'd0}; pix_ready = 1'b1;
        @(posedge clk); #1; cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        post("mid_second_pixel_x", int'(pix_x), 1);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        post("mid_pix_valid", int'(pix_valid), 0);
        post("mid_busy", int'(busy), 0);
        post("mid_pix_x", int'(pix_x), 0);
        nbad = int'(done);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            nbad += int'(done) + int'(pix_valid);
        end
        post("mid_no_done", nbad, 0);
        @(posedge clk); #1;
        run_line("after_rst", 7, 3, 4, 1, 16'h2468, 4'b1111);

        repeat (3) @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Run-time bound.
    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
